poly_voice_manager: RTL and testbench

// - N-voice successor to the mono MIDI->sample path: takes parsed MIDI note events, allocates voices, mixes per-voice samples.
// - Sits between MIDIParse and N parallel SampleGenerator/filter/envelope chains; mixed output feeds the DAC.
// - Mono path replaced: polyphony, retrigger, oldest-voice stealing, saturating time-multiplexed mix.

---
 rtl/poly_voice_manager_pkg.sv | 23 ++
 rtl/poly_voice_manager_if.sv | 35 +++
 rtl/poly_voice_manager_voice_mixer.sv | 81 ++++++++
 rtl/poly_voice_manager.sv | 206 ++++++++++++++++++++
 tb/tb_poly_voice_manager.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/poly_voice_manager_pkg.sv
// Shared constants and state encodings for the polyphonic voice manager.
package poly_voice_manager_pkg;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } alloc_state_e;

    typedef enum logic [0:0] {
        MixIdle,
        MixAcc
    } mix_state_e;

    // Index width that stays at least 1 bit for tiny voice counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_voice_manager_if.sv
// Event, voice-table and mix signals between the voice manager and its neighbours.
interface poly_voice_manager_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 12
);
    import poly_voice_manager_pkg::*;

    logic                           evt_valid;
    logic                           evt_ready;
    logic                           evt_on;
    logic [NOTE_W-1:0]              evt_note;
    logic [VEL_W-1:0]               evt_vel;
    logic [NOTE_W*NUM_VOICES-1:0]   voice_note;
    logic [VEL_W*NUM_VOICES-1:0]    voice_vel;
    logic [NUM_VOICES-1:0]          voice_gate;
    logic [NUM_VOICES-1:0]          voice_trig;
    logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample;
    logic                           sample_strobe;
    logic [SAMPLE_W-1:0]            mix_sample;
    logic                           mix_valid;
    logic                           dropped;

    modport master (
        output evt_valid, evt_on, evt_note, evt_vel, voice_sample, sample_strobe,
        input  evt_ready, voice_note, voice_vel, voice_gate, voice_trig, mix_sample, mix_valid,
               dropped
    );

    modport slave (
        input  evt_valid, evt_on, evt_note, evt_vel, voice_sample, sample_strobe,
        output evt_ready, voice_note, voice_vel, voice_gate, voice_trig, mix_sample, mix_valid,
               dropped
    );

endinterface

// File: rtl/poly_voice_manager_voice_mixer.sv
// Time-multiplexed mixer: one voice per cycle, then shift and clip to the sample range.
module poly_voice_manager_voice_mixer
    import poly_voice_manager_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned MIX_SHIFT  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           strobe,
    input  logic [NUM_VOICES-1:0]          gate,
    input  logic [SAMPLE_W*NUM_VOICES-1:0] samples,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_valid
);
    localparam int unsigned IdxW = clog2_min1(NUM_VOICES);
    localparam int unsigned SumW = SAMPLE_W + IdxW;
    localparam logic [SumW-1:0] SatMax = {{(SumW-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

    mix_state_e          state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [SumW-1:0]     sum_q, sum_d;
    logic [SAMPLE_W-1:0] mix_sample_q, mix_sample_d;
    logic                mix_valid_q, mix_valid_d;
    logic [SumW-1:0]     addend, sum_next, shifted;

    always_comb begin
        // Gate is read live so a gate change lands at that voice's own slot.
        addend   = gate[idx_q] ? SumW'(samples[idx_q*SAMPLE_W +: SAMPLE_W]) : '0;
        sum_next = sum_q + addend;
        shifted  = sum_next >> MIX_SHIFT;

        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        mix_sample_d = mix_sample_q;
        mix_valid_d  = 1'b0;
        unique case (state_q)
            MixIdle: begin
                if (strobe) begin
                    state_d = MixAcc;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            MixAcc: begin
                sum_d = sum_next;
                if (idx_q == IdxW'(NUM_VOICES - 1)) begin
                    state_d      = MixIdle;
                    mix_valid_d  = 1'b1;
                    mix_sample_d = (shifted > SatMax) ? SatMax[SAMPLE_W-1:0]
                                                      : shifted[SAMPLE_W-1:0];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = MixIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MixIdle;
            idx_q        <= '0;
            sum_q        <= '0;
            mix_sample_q <= '0;
            mix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            mix_sample_q <= mix_sample_d;
            mix_valid_q  <= mix_valid_d;
        end
    end

    assign mix_sample = mix_sample_q;
    assign mix_valid  = mix_valid_q;

endmodule

// File: rtl/poly_voice_manager.sv
// N-voice allocator with retrigger and age tracking, plus mixer instance.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping when all voices are busy.
module poly_voice_manager
    import poly_voice_manager_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned AGE_W      = 4,
    parameter int unsigned MIX_SHIFT  = 2
) (
    input logic                CLK_50MHZ,
    input logic                RST_N,
    poly_voice_manager_if.slave bus
);
    localparam int unsigned IdxW = clog2_min1(NUM_VOICES);
    localparam logic [AGE_W-1:0] AgeMax = '1;

    alloc_state_e          state_q, state_d;
    logic [IdxW-1:0]       scan_q, scan_d;
    logic                  ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]     ev_note_q, ev_note_d;
    logic [VEL_W-1:0]      ev_vel_q, ev_vel_d;
    logic                  match_found_q, match_found_d, free_found_q, free_found_d;
    logic                  old_found_q, old_found_d;
    logic [IdxW-1:0]       match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
    logic [AGE_W-1:0]      old_age_q, old_age_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [VEL_W-1:0]      vel_q  [NUM_VOICES];
    logic [VEL_W-1:0]      vel_d  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
    logic                  dropped_q, dropped_d;
    logic                  have_tgt;
    logic [IdxW-1:0]       tgt;

    always_comb begin
        state_d       = state_q;
        scan_d        = scan_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_vel_d      = ev_vel_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        note_d        = note_q;
        vel_d         = vel_q;
        age_d         = age_q;
        gate_d        = gate_q;
        trig_d        = '0;
        dropped_d     = 1'b0;
        have_tgt      = 1'b0;
        tgt           = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.evt_valid) begin
                    state_d       = StScan;
                    scan_d        = '0;
                    ev_on_d       = bus.evt_on && (bus.evt_vel != '0);
                    ev_note_d     = bus.evt_note;
                    ev_vel_d      = bus.evt_vel;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_found_d   = 1'b0;
                end
            end
            StScan: begin
                if (gate_q[scan_q] && note_q[scan_q] == ev_note_q && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_q;
                end
                if (!gate_q[scan_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_q;
                end
                // Strict compare keeps the lowest index on an age tie.
                if (gate_q[scan_q] && (!old_found_q || age_q[scan_q] > old_age_q)) begin
                    old_found_d = 1'b1;
                    old_idx_d   = scan_q;
                    old_age_d   = age_q[scan_q];
                end
                if (scan_q == IdxW'(NUM_VOICES - 1)) begin
                    state_d = StCommit;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (ev_on_q) begin
                    if (match_found_q) begin
                        have_tgt = 1'b1;
                        tgt      = match_idx_q;
                    end else if (free_found_q) begin
                        have_tgt = 1'b1;
                        tgt      = free_idx_q;
                    end else begin
                        tgt = old_idx_q;
`ifdef VOICE_STEAL_EN
                        have_tgt = old_found_q;
`else
                        have_tgt  = 1'b0;
                        dropped_d = 1'b1;
`endif
                    end
                    if (have_tgt) begin
                        for (int i = 0; i < int'(NUM_VOICES); i++) begin
                            if (IdxW'(i) == tgt) begin
                                note_d[i] = ev_note_q;
                                vel_d[i]  = ev_vel_q;
                                gate_d[i] = 1'b1;
                                age_d[i]  = '0;
                                trig_d[i] = 1'b1;
                            end else if (gate_q[i] && age_q[i] != AgeMax) begin
                                age_d[i] = age_q[i] + 1'b1;
                            end
                        end
                    end
                end else begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (gate_q[i] && note_q[i] == ev_note_q) gate_d[i] = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= StIdle;
            scan_q        <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
            dropped_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            scan_q        <= scan_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_vel_q      <= ev_vel_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            gate_q        <= gate_d;
            trig_q        <= trig_d;
            dropped_q     <= dropped_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            age_q         <= age_d;
        end
    end

    always_comb begin
        bus.voice_note = '0;
        bus.voice_vel  = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            bus.voice_note[NOTE_W*i +: NOTE_W] = note_q[i];
            bus.voice_vel[VEL_W*i +: VEL_W]    = vel_q[i];
        end
    end

    assign bus.evt_ready  = (state_q == StIdle);
    assign bus.voice_gate = gate_q;
    assign bus.voice_trig = trig_q;
    assign bus.dropped    = dropped_q;

    poly_voice_manager_voice_mixer #(
        .NUM_VOICES (NUM_VOICES),
        .SAMPLE_W   (SAMPLE_W),
        .MIX_SHIFT  (MIX_SHIFT)
    ) u_mixer (
        .clk        (CLK_50MHZ),
        .rst_n      (RST_N),
        .strobe     (bus.sample_strobe),
        .gate       (gate_q),
        .samples    (bus.voice_sample),
        .mix_sample (bus.mix_sample),
        .mix_valid  (bus.mix_valid)
    );

endmodule

// File: tb/tb_poly_voice_manager.sv
// Scoreboard bench: drivers queue expected voice-table / mix results, a monitor pops and compares.
module tb_poly_voice_manager;

`ifdef VOICE_STEAL_EN
    localparam bit Steal = 1'b1;
`else
    localparam bit Steal = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  gates;
        logic [3:0]  trig;
        logic        dropped;
        logic [27:0] notes;
        logic [27:0] vels;
    } alloc_exp_t;

    typedef struct packed {
        logic [11:0] s;
        int          cyc;
    } mix_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alloc_exp_t aq[$];
    mix_exp_t   mq[$];

    poly_voice_manager_if #(.NUM_VOICES(4), .SAMPLE_W(12)) bus ();

    poly_voice_manager #(
        .NUM_VOICES (4),
        .SAMPLE_W   (12),
        .AGE_W      (4),
        .MIX_SHIFT  (2)
    ) dut (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] pk(input logic [6:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    // Monitor
    bit         pending = 1'b0;
    bit         prev_ready = 1'b1;
    bit         quiet_chk = 1'b0;
    int         acc_cyc = 0;
    always @(negedge clk) begin
        alloc_exp_t a;
        mix_exp_t   m;
        if (!rst_n) begin
            pending    = 1'b0;
            prev_ready = 1'b1;
            quiet_chk  = 1'b0;
        end else begin
            if (quiet_chk) begin
                check("pulse_one_cycle", 64'({bus.voice_trig, bus.dropped}), 64'(0));
                quiet_chk = 1'b0;
            end
            if (pending && bus.evt_ready && !prev_ready) begin
                pending = 1'b0;
                quiet_chk = 1'b1;
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected: completion with no expectation at cycle %0d", cyc);
                end else begin
                    a = aq.pop_front();
                    check("evt_latency", 64'(cyc - acc_cyc), 64'(6));
                    check("voice_gate", 64'(bus.voice_gate), 64'(a.gates));
                    check("voice_trig", 64'(bus.voice_trig), 64'(a.trig));
                    check("dropped", 64'(bus.dropped), 64'(a.dropped));
                    check("voice_note", 64'(bus.voice_note), 64'(a.notes));
                    check("voice_vel", 64'(bus.voice_vel), 64'(a.vels));
                end
            end
            if (bus.evt_valid && bus.evt_ready) begin
                pending = 1'b1;
                acc_cyc = cyc;
            end
            prev_ready = bus.evt_ready;
            if (bus.mix_valid) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mix_unexpected: mix_valid with no expectation, sample %0d",
                             bus.mix_sample);
                end else begin
                    m = mq.pop_front();
                    check("mix_sample", 64'(bus.mix_sample), 64'(m.s));
                    check("mix_latency", 64'(cyc - m.cyc), 64'(5));
                end
            end
        end
    end

    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int n = 0;
        @(posedge clk); #1;
        bus.evt_valid = 1'b1;
        bus.evt_on    = on;
        bus.evt_note  = note;
        bus.evt_vel   = vel;
        @(posedge clk); #1;
        bus.evt_valid = 1'b0;
        while (!bus.evt_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("evt_done_in_time", 64'(n < 20), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic sendx(input logic on, input logic [6:0] note, input logic [6:0] vel,
                         input logic [3:0] g, input logic [3:0] t, input logic d,
                         input logic [27:0] notes, input logic [27:0] vels);
        alloc_exp_t a;
        a = '{gates: g, trig: t, dropped: d, notes: notes, vels: vels};
        aq.push_back(a);
        send(on, note, vel);
    endtask

    task automatic do_mix(input logic [11:0] exp, input bit twice);
        mix_exp_t m;
        @(posedge clk); #1;
        bus.sample_strobe = 1'b1;
        m.s   = exp;
        m.cyc = cyc;
        mq.push_back(m);
        @(posedge clk); #1;
        bus.sample_strobe = 1'b0;
        if (twice) begin
            @(posedge clk); #1;
            bus.sample_strobe = 1'b1;
            @(posedge clk); #1;
            bus.sample_strobe = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] n0, v0;
        n0 = Steal ? 7'd72 : 7'd60;
        v0 = Steal ? 7'd40 : 7'd100;
        bus.evt_valid     = 1'b0;
        bus.evt_on        = 1'b0;
        bus.evt_note      = '0;
        bus.evt_vel       = '0;
        bus.voice_sample  = '0;
        bus.sample_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(bus.evt_ready), 64'(1));
        check("rst_gate", 64'(bus.voice_gate), 64'(0));
        check("rst_note_vel", 64'({bus.voice_note, bus.voice_vel}), 64'(0));
        check("rst_pulses", 64'({bus.voice_trig, bus.dropped, bus.mix_valid}), 64'(0));
        check("rst_mix", 64'(bus.mix_sample), 64'(0));

        // Allocation, note-off, refill, full table, retrigger.
        sendx(1, 60, 100, 4'b0001, 4'b0001, 0, pk(0, 0, 0, 60), pk(0, 0, 0, 100));
        sendx(1, 64, 90, 4'b0011, 4'b0010, 0, pk(0, 0, 64, 60), pk(0, 0, 90, 100));
        sendx(1, 67, 80, 4'b0111, 4'b0100, 0, pk(0, 67, 64, 60), pk(0, 80, 90, 100));
        sendx(1, 71, 70, 4'b1111, 4'b1000, 0, pk(71, 67, 64, 60), pk(70, 80, 90, 100));
        sendx(0, 64, 64, 4'b1101, 4'b0000, 0, pk(71, 67, 64, 60), pk(70, 80, 90, 100));
        sendx(1, 62, 50, 4'b1111, 4'b0010, 0, pk(71, 67, 62, 60), pk(70, 80, 50, 100));
        sendx(1, 72, 40, 4'b1111, Steal ? 4'b0001 : 4'b0000, !Steal,
              pk(71, 67, 62, n0), pk(70, 80, 50, v0));
        sendx(1, 67, 110, 4'b1111, 4'b0100, 0, pk(71, 67, 62, n0), pk(70, 110, 50, v0));
        sendx(1, 67, 0, 4'b1011, 4'b0000, 0, pk(71, 67, 62, n0), pk(70, 110, 50, v0));
        sendx(0, 99, 5, 4'b1011, 4'b0000, 0, pk(71, 67, 62, n0), pk(70, 110, 50, v0));
        sendx(1, 80, 1, 4'b1111, 4'b0100, 0, pk(71, 80, 62, n0), pk(70, 1, 50, v0));

        // Mixer.
        bus.voice_sample = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        do_mix(12'd4095, 0);
        bus.voice_sample = {12'd4000, 12'd4000, 12'd4000, 12'd4000};
        do_mix(12'd4000, 0);
        sendx(0, 62, 0, 4'b1101, 4'b0000, 0, pk(71, 80, 62, n0), pk(70, 1, 50, v0));
        sendx(0, 71, 0, 4'b0101, 4'b0000, 0, pk(71, 80, 62, n0), pk(70, 1, 50, v0));
        bus.voice_sample = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        do_mix(12'd2047, 0);
        bus.voice_sample = {12'd400, 12'd1004, 12'd200, 12'd1000};
        do_mix(12'd501, 0);
        do_mix(12'd501, 1);

        // Reset while the allocator is scanning.
        @(posedge clk); #1;
        bus.evt_valid = 1'b1;
        bus.evt_on    = 1'b1;
        bus.evt_note  = 7'd90;
        bus.evt_vel   = 7'd90;
        @(posedge clk); #1;
        bus.evt_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(bus.evt_ready), 64'(1));
        check("abort_gate", 64'(bus.voice_gate), 64'(0));
        check("abort_note", 64'(bus.voice_note), 64'(0));
        check("abort_mix", 64'(bus.mix_sample), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        sendx(1, 55, 10, 4'b0001, 4'b0001, 0, pk(0, 0, 0, 55), pk(0, 0, 0, 10));

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("alloc_queue_drained", 64'(aq.size()), 64'(0));
        check("mix_queue_drained", 64'(mq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
